// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter/sequencer for a shared W-bit parameter register.
// Optional ARB_LOCK_EN: a locking owner keeps winning for atomic write bursts.
module reg_write_arbiter #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   wdata,
   input  logic [N-1:0]     lock,
   output logic [N-1:0]     gnt,
   output logic             reg_lden,
   output logic [W-1:0]     reg_d,
   output logic             busy,
   output logic [$clog2(N)-1:0] owner
);

   localparam int unsigned IW = $clog2(N);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   ptr, ptr_nx, owner_nx;
   logic [W-1:0]    reg_d_nx;
   logic [N-1:0]    gnt_nx;
   logic            reg_lden_nx, busy_nx;
   logic            found, lock_hit;
   logic [IW-1:0]   win;
   logic [IW:0]     cand;
   logic [W-1:0]    wd [N];

   for (genvar g = 0; g < int'(N); g++) begin : g_unpack
      assign wd[g] = wdata[g*W +: W];
   end

`ifdef ARB_LOCK_EN
   // Owner index is only meaningful once a write has actually been granted.
   logic owner_vld;
   always_ff @(posedge clk) begin
      if (!reset)
         owner_vld <= 1'b0;
      else if (state == IDLE && found)
         owner_vld <= 1'b1;
   end
`else
   logic unused_lock;
   assign unused_lock = ^lock;
`endif

   // Winner select: first requester at or after ptr, wrapping around.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      lock_hit = 1'b0;
      cand     = '0;
      for (int k = 0; k < int'(N); k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N))
            cand = cand - (IW+1)'(N);
         if (!found && req[cand[IW-1:0]]) begin
            found = 1'b1;
            win   = cand[IW-1:0];
         end
      end
`ifdef ARB_LOCK_EN
      if (owner_vld && lock[owner] && req[owner]) begin
         found    = 1'b1;
         win      = owner;
         lock_hit = 1'b1;
      end
`endif
   end

   // Next state and next registered outputs.
   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      owner_nx    = owner;
      reg_d_nx    = reg_d;
      gnt_nx      = '0;
      reg_lden_nx = 1'b0;
      busy_nx     = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nx    = WRITE;
               owner_nx    = win;
               reg_d_nx    = wd[win];
               gnt_nx      = N'(1) << win;
               reg_lden_nx = 1'b1;
               busy_nx     = 1'b1;
               if (!lock_hit)
                  ptr_nx = (win == IW'(N-1)) ? '0 : win + IW'(1);
            end
         end
         WRITE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         owner    <= '0;
         reg_d    <= '0;
         gnt      <= '0;
         reg_lden <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         owner    <= owner_nx;
         reg_d    <= reg_d_nx;
         gnt      <= gnt_nx;
         reg_lden <= reg_lden_nx;
         busy     <= busy_nx;
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: reference model pushes expected
// grants at each arbitration edge, a negedge monitor pops and compares.
module tb_reg_write_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   lock;
   logic [N-1:0]   gnt;
   logic           reg_lden;
   logic [W-1:0]   reg_d;
   logic           busy;
   logic [1:0]     owner;
   logic [W-1:0]   q = '0;

   reg_write_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .reset(reset), .req(req), .wdata(wdata), .lock(lock),
      .gnt(gnt), .reg_lden(reg_lden), .reg_d(reg_d), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   // The shared register being written.
   always @(posedge clk) if (reg_lden) q <= reg_d;

   typedef struct { int idx; logic [W-1:0] data; } exp_t;
   exp_t exp_q[$];
   int   glog_idx[$];
   int   glog_cyc[$];
   int   checks = 0, errors = 0, cyc = 0;
   bit   mon_en = 0;

   // Reference model state
   bit          m_in_write = 0, m_owner_vld = 0;
   int          m_ptr = 0, m_owner = 0;
   logic [W-1:0] m_regd = '0, m_q = '0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Reference model: one arbitration per idle edge, rotating from ptr.
   always @(posedge clk) begin
      int win;
      bit locked;
      exp_t e;
      cyc++;
      if (m_in_write) m_q = m_regd;
      if (!reset) begin
         m_in_write = 0; m_ptr = 0; m_owner = 0; m_regd = '0; m_owner_vld = 0;
         mon_en = 1;
      end else if (m_in_write) begin
         m_in_write = 0;
      end else if (req != 0) begin
         win = -1;
         locked = 0;
`ifdef ARB_LOCK_EN
         if (m_owner_vld && lock[m_owner] && req[m_owner]) begin
            win = m_owner;
            locked = 1;
         end
`endif
         for (int k = 0; k < N; k++)
            if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         e.idx  = win;
         e.data = wdata[win*W +: W];
         exp_q.push_back(e);
         m_owner = win;
         m_owner_vld = 1;
         m_regd = e.data;
         if (!locked) m_ptr = (win + 1) % N;
         m_in_write = 1;
      end
   end

   // Monitor: every output cycle is compared against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      logic [N-1:0] eg;
      if (mon_en) begin
         if (gnt != 0 || reg_lden || busy) begin
            if (exp_q.size() == 0) begin
               chk("spurious_write", 32'(gnt), 32'(0));
            end else begin
               e = exp_q.pop_front();
               eg = N'(1) << e.idx;
               chk("gnt", 32'(gnt), 32'(eg));
               chk("reg_d_write", 32'(reg_d), 32'(e.data));
               chk("lden_busy", 32'({reg_lden, busy}), 32'(2'b11));
               chk("owner_write", 32'(owner), 32'(e.idx));
               glog_idx.push_back(e.idx);
               glog_cyc.push_back(cyc);
            end
         end else begin
            if (exp_q.size() != 0) begin
               chk("missing_grant", 32'(gnt), 32'(N'(1) << exp_q[0].idx));
               void'(exp_q.pop_front());
            end
            chk("reg_d_hold", 32'(reg_d), 32'(m_regd));
            chk("owner_hold", 32'(owner), 32'(m_owner));
         end
         chk("q", 32'(q), 32'(m_q));
      end
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic set_wd(int i, logic [W-1:0] v);
      wdata[i*W +: W] = v;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      step(1);
      reset = 1'b1;
   endtask

   initial begin
      int base;
      reset = 1'b0; req = '1; lock = '0; wdata = '0;

      // Reset held with all requests high
      repeat (3) begin
         step(1);
         chk("rst_gnt", 32'(gnt), 0);
         chk("rst_lden", 32'(reg_lden), 0);
         chk("rst_reg_d", 32'(reg_d), 0);
         chk("rst_owner", 32'(owner), 0);
      end
      req = '0; reset = 1'b1;
      step(1);

      // Single write from requester 2
      req = 4'b0100; set_wd(2, 8'hA5);
      step(1);
      chk("single_gnt", 32'(gnt), 32'(4'b0100));
      chk("single_lden", 32'(reg_lden), 1);
      chk("single_reg_d", 32'(reg_d), 32'h A5);
      step(1);
      chk("single_q", 32'(q), 32'hA5);
      chk("single_owner", 32'(owner), 2);
      req = '0;
      step(2);

      // Rotation with all requesters held
      pulse_reset();
      base = glog_idx.size();
      for (int i = 0; i < N; i++) set_wd(i, W'(8'h10 + i));
      req = '1;
      step(16);
      req = '0;
      step(2);
      chk("rot_count", 32'(glog_idx.size() - base), 8);
      for (int j = 0; j < 8 && base + j < glog_idx.size(); j++) begin
         chk("rot_order", 32'(glog_idx[base+j]), 32'(j % N));
         if (j > 0) chk("rot_spacing", 32'(glog_cyc[base+j] - glog_cyc[base+j-1]), 2);
      end

      // Data changed during WRITE must not reach the register
      pulse_reset();
      req = 4'b0010; set_wd(1, 8'h11);
      step(1);
      set_wd(1, 8'h22);
      step(1);
      req = '0;
      step(1);
      chk("stab_q", 32'(q), 32'h11);
      chk("stab_reg_d", 32'(reg_d), 32'h11);

      // Reset asserted during WRITE
      pulse_reset();
      req = 4'b0010; set_wd(1, 8'h5C);
      step(1);
      chk("mid_gnt", 32'(gnt), 32'(4'b0010));
      reset = 1'b0;
      step(1);
      chk("mid_rst_outs", 32'({gnt, reg_lden, busy, reg_d, owner}), 0);
      reset = 1'b1;
      base = glog_idx.size();
      step(2);
      chk("mid_regrant_cnt", 32'(glog_idx.size() - base), 1);
      if (glog_idx.size() > base) chk("mid_regrant_idx", 32'(glog_idx[base]), 1);
      req = '0;
      step(2);

      // Lock burst
      pulse_reset();
      base = glog_idx.size();
      set_wd(0, 8'hC0); set_wd(1, 8'hC1);
      req = 4'b0011; lock = 4'b0001;
      step(6);
`ifdef ARB_LOCK_EN
      lock = '0;
      step(2);
      req = '0;
      step(2);
      chk("lock_count", 32'(glog_idx.size() - base), 4);
      for (int j = 0; j < 4 && base + j < glog_idx.size(); j++)
         chk("lock_order", 32'(glog_idx[base+j]), (j < 3) ? 0 : 1);
`else
      req = '0; lock = '0;
      step(2);
      chk("nolock_count", 32'(glog_idx.size() - base), 3);
      for (int j = 0; j < 3 && base + j < glog_idx.size(); j++)
         chk("nolock_order", 32'(glog_idx[base+j]), 32'(j % 2));
`endif

      // Randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         req   = N'($urandom);
         wdata = $urandom;
         lock  = N'($urandom);
         reset = ($urandom_range(0, 39) != 0);
         step(1);
      end
      reset = 1'b1; req = '0; lock = '0;
      step(3);
      chk("drain_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter and sequencer for a shared W-bit parameter register in the WimpFi datapath. Up to N requesters (e.g. MAC control, config UART, test logic) request writes. The block picks one winner per arbitration, captures its data, and drives the register's load-enable and data inputs for exactly one cycle. The winner is acknowledged with a one-cycle grant pulse coincident with the load.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `W`, default 8: register data width.
- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-low. 0 resets the block on the next posedge.
- `req` input N: per-requester write request; bit i belongs to requester i.
- `wdata` input N*W: requester i data on bits [i*W +: W].
- `lock` input N: per-requester ownership hold. Used only with `ARB_LOCK_EN` (see Configuration).
- `gnt` output N: one-hot, one-cycle pulse; the write of requester i commits this cycle.
- `reg_lden` output 1: load enable to the shared register.
- `reg_d` output W: data to the shared register.
- `busy` output 1: high while a write is in progress (state WRITE).
- `owner` output $clog2(N): index of the most recent winner.

## Operation
- Two states: IDLE and WRITE.
- IDLE: if any `req` bit is set, select a winner by round-robin starting at pointer `ptr`. The winner is the lowest index i ≥ `ptr` with `req[i]`=1, wrapping to 0..`ptr`-1.
- On the IDLE→WRITE transition:
  - latch `wdata` of the winner into an internal capture register;
  - set `owner` to the winner index;
  - set `ptr` to winner+1, with wrap: N-1 → 0.
- IDLE with `req` all zero: stay in IDLE, outputs idle, `ptr` unchanged.
- WRITE (exactly one cycle): `reg_lden`=1, `reg_d`=captured data, `gnt[owner]`=1, `busy`=1. Next state is always IDLE.
- Protocol:
  - A requester holds `req` and `wdata` stable until it sees its `gnt`.
  - It drops `req` in the cycle after `gnt`, or keeps it high to request a further write.
  - If `req[i]` drops before `gnt`, the write still completes with the captured data and `gnt[i]` still pulses.
- `wdata` changes after capture do not affect `reg_d`.
- Outside WRITE: `reg_lden`=0, `gnt`=0, `busy`=0. `reg_d` holds the last captured value.
- Only one grant is ever outstanding; `gnt` is never multi-hot.

## Timing
- Reset values: `gnt`=0, `reg_lden`=0, `reg_d`=0, `busy`=0, `owner`=0, `ptr`=0, state IDLE.
- Latency: `req` seen in IDLE at edge t. `reg_lden`, `gnt` and `busy` are high during cycle t+1. The register's `q` shows the new data from edge t+2.
- Throughput: one write per 2 cycles. Back-to-back requests arbitrate again in the IDLE cycle after WRITE.
- Fairness: with all N requesters continuously asserted, grants rotate 0,1,…,N-1,0. No requester waits more than N writes (2N cycles) after first assertion.
- `req` arriving during WRITE is ignored until the following IDLE cycle.
- Reset low during WRITE: the next edge forces IDLE and all outputs to reset values. The in-flight `gnt`/`reg_lden` pulse of that cycle is not repeated. The requester keeps `req` high and rearbitrates.
- Reset has priority over all other inputs.

## Configuration
- Macro: `ARB_LOCK_EN`.
- Defined:
  - If `lock[owner]`=1 and `req[owner]`=1 in IDLE, `owner` wins again regardless of `ptr`, and `ptr` is not advanced.
  - This lets a requester perform an atomic burst of writes.
  - Lock is released when `lock[owner]` or `req[owner]` is 0; normal round-robin then resumes from `ptr`.
- Not defined: `lock` is ignored (unconnected internally) and arbitration is pure round-robin.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with all `req`=1. Required: `gnt`=0, `reg_lden`=0, `reg_d`=0, `owner`=0 throughout.
- Single write: `req`=0b0100, `wdata[2]`=0xA5 at edge t. Required: cycle t+1 `gnt`=0b0100, `reg_lden`=1, `reg_d`=0xA5; register `q`=0xA5 at t+2; `owner`=2.
- Rotation: `req`=0b1111 held for 8 writes. Required: grant order 0,1,2,3,0,1,2,3, exactly 2 cycles apart.
- Data stability: change `wdata[1]` from 0x11 to 0x22 in the WRITE cycle of requester 1. Required: `reg_d`=0x11 and register `q`=0x11.
- Reset mid-operation: drive `reset`=0 during WRITE with `req`=0b0010. Required: next cycle all outputs 0. After release, requester 1 is granted again within 2 cycles.
- Lock (`ARB_LOCK_EN` defined): `req`=0b0011, `lock`=0b0001. Required: requester 0 granted 3 times consecutively. After `lock`=0, the next grant goes to requester 1. Without the macro, grants alternate 0,1,0.
